// File: rtl/delay_pkg.sv
// Shared types and default sizing for the multi-channel delay/periodic pulse generator.
package delay_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } dly_state_t;

  typedef enum logic {
    MODE_ONESHOT  = 1'b0,
    MODE_PERIODIC = 1'b1
  } dly_mode_t;

  localparam int DLY_NCH   = 4;
  localparam int DLY_CBITS = 10;

endpackage

// File: rtl/delay_timer_bank_if.sv
// Control/status bundle of the timer bank: per-channel start/stop/mode/period in, pulse/busy/done out.
interface delay_timer_bank_if #(
  parameter int NCH   = delay_pkg::DLY_NCH,
  parameter int CBITS = delay_pkg::DLY_CBITS
);

  logic [NCH-1:0]       start;
  logic [NCH-1:0]       stop;
  logic [NCH-1:0]       mode;
  logic [NCH*CBITS-1:0] period;
  logic [NCH-1:0]       pulse;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       done;
  logic                 any_pulse;

  modport master (
    output start, stop, mode, period,
    input  pulse, busy, done, any_pulse
  );

  modport slave (
    input  start, stop, mode, period,
    output pulse, busy, done, any_pulse
  );

endinterface

// File: rtl/delay_chan.sv
// One timer channel: IDLE/RUN state machine with counter, shadowed period and one-cycle terminal pulse.
module delay_chan
  import delay_pkg::*;
#(
  parameter int CBITS = DLY_CBITS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  dly_mode_t        mode,
  input  logic [CBITS-1:0] period,
  output logic             pulse,
  output logic             busy,
  output logic             done,
  output logic             pulse_set
);

  dly_state_t       state_reg;
  dly_mode_t        mode_reg;
  logic [CBITS-1:0] cnt_reg;
  logic [CBITS-1:0] shadow_reg;
  logic             pulse_reg;
  logic             done_reg;
  logic             pulse_next;

  // Terminal count fires only when neither stop nor a retrigger claims this edge.
  always_comb begin
    pulse_next = 1'b0;
    if (!stop && !start && state_reg == ST_RUN && cnt_reg == shadow_reg) begin
      pulse_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      mode_reg   <= MODE_ONESHOT;
      cnt_reg    <= '0;
      shadow_reg <= '0;
      pulse_reg  <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      pulse_reg <= pulse_next;
      if (stop) begin
        state_reg <= ST_IDLE;
        cnt_reg   <= '0;
      end else if (start) begin
        state_reg  <= ST_RUN;
        cnt_reg    <= '0;
        shadow_reg <= period;
        mode_reg   <= mode;
        done_reg   <= 1'b0;
      end else if (state_reg == ST_RUN) begin
        if (cnt_reg == shadow_reg) begin
          cnt_reg <= '0;
          if (mode_reg == MODE_PERIODIC) begin
            shadow_reg <= period;
          end else begin
            state_reg <= ST_IDLE;
            done_reg  <= 1'b1;
          end
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  end

  assign pulse     = pulse_reg;
  assign busy      = (state_reg == ST_RUN);
  assign done      = done_reg;
  assign pulse_set = pulse_next;

  // Cycles spent busy without any progress event; bounded by the largest period plus one.
  localparam logic [CBITS:0] AGE_MAX = {1'b1, {CBITS{1'b0}}};
  logic [CBITS:0] age_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age_reg <= '0;
    end else if (!busy || stop || start || pulse_reg) begin
      age_reg <= '0;
    end else if (age_reg != '1) begin
      age_reg <= age_reg + 1'b1;
    end
  end

  a_pulse_gap: assert property (@(posedge clk) disable iff (!rst_n)
      (pulse_reg && pulse_next) |-> (shadow_reg == '0 && mode_reg == MODE_PERIODIC));

  a_idle_pulse: assert property (@(posedge clk) disable iff (!rst_n)
      (pulse_reg && !busy) |-> $past(busy));

  a_progress: assert property (@(posedge clk) disable iff (!rst_n)
      busy |-> (age_reg <= AGE_MAX));

endmodule

// File: rtl/delay_timer_bank.sv
// Bank of independent delay/periodic pulse channels with a registered OR of all pulses.
module delay_timer_bank
  import delay_pkg::*;
#(
  parameter int NCH   = DLY_NCH,
  parameter int CBITS = DLY_CBITS
) (
  input  logic              clk,
  input  logic              rst_n,
  delay_timer_bank_if.slave bus
);

  logic [NCH-1:0] pulse_w;
  logic [NCH-1:0] busy_w;
  logic [NCH-1:0] done_w;
  logic [NCH-1:0] pulse_set_w;
  logic           any_pulse_reg;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    delay_chan #(
      .CBITS(CBITS)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (bus.start[gi]),
      .stop     (bus.stop[gi]),
      .mode     (dly_mode_t'(bus.mode[gi])),
      .period   (bus.period[gi*CBITS +: CBITS]),
      .pulse    (pulse_w[gi]),
      .busy     (busy_w[gi]),
      .done     (done_w[gi]),
      .pulse_set(pulse_set_w[gi])
    );
  end

  // Built from the channels' next-pulse terms so it lands in the same cycle as pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_pulse_reg <= 1'b0;
    end else begin
      any_pulse_reg <= |pulse_set_w;
    end
  end

  assign bus.pulse     = pulse_w;
  assign bus.busy      = busy_w;
  assign bus.done      = done_w;
  assign bus.any_pulse = any_pulse_reg;

endmodule

// File: tb/tb_delay_timer_bank.sv
// Directed bench for delay_timer_bank: table of single-channel vectors plus multi-cycle corner sequences.
module tb_delay_timer_bank;
  import delay_pkg::*;

  localparam int NCH   = 4;
  localparam int CBITS = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  delay_timer_bank_if #(.NCH(NCH), .CBITS(CBITS)) bus ();

  delay_timer_bank #(.NCH(NCH), .CBITS(CBITS)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    int   ch;
    logic m;
    int   p;
    int   exp_lat;
    logic exp_busy;
    logic exp_done;
  } vec_t;

  vec_t vecs[6];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_chan(input int ch, input logic m, input int p);
    bus.mode[ch] = m;
    bus.period[ch*CBITS +: CBITS] = p[CBITS-1:0];
  endtask

  task automatic start_ch(input int ch);
    bus.start[ch] = 1'b1;
    step();
    bus.start[ch] = 1'b0;
  endtask

  task automatic stop_ch(input int ch);
    bus.stop[ch] = 1'b1;
    step();
    bus.stop[ch] = 1'b0;
  endtask

  // Steps until pulse[ch] is seen; lat = cycles stepped, or -1 if the budget ran out.
  task automatic wait_pulse(input int ch, input int maxc, output int lat);
    lat = -1;
    for (int i = 1; i <= maxc; i++) begin
      step();
      if (bus.pulse[ch] === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int ch, input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (bus.pulse[ch] !== 1'b0) cnt++;
    end
  endtask

  int lat;
  int npul;

  initial begin
    vecs[0] = '{ch:1, m:1'b0, p:0,  exp_lat:1,  exp_busy:1'b0, exp_done:1'b1};
    vecs[1] = '{ch:2, m:1'b0, p:1,  exp_lat:2,  exp_busy:1'b0, exp_done:1'b1};
    vecs[2] = '{ch:3, m:1'b0, p:7,  exp_lat:8,  exp_busy:1'b0, exp_done:1'b1};
    vecs[3] = '{ch:0, m:1'b0, p:12, exp_lat:13, exp_busy:1'b0, exp_done:1'b1};
    vecs[4] = '{ch:1, m:1'b1, p:2,  exp_lat:3,  exp_busy:1'b1, exp_done:1'b0};
    vecs[5] = '{ch:2, m:1'b1, p:0,  exp_lat:1,  exp_busy:1'b1, exp_done:1'b0};

    bus.start  = '0;
    bus.stop   = '0;
    bus.mode   = '0;
    bus.period = '0;
    rst_n      = 1'b0;
    step(2);
    check("reset_pulse", 32'(bus.pulse), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_done", 32'(bus.done), 0);
    check("reset_any", 32'(bus.any_pulse), 0);
    rst_n = 1'b1;
    step(2);

    // One-shot P=5 on ch0
    set_chan(0, 1'b0, 5);
    start_ch(0);
    check("t1_busy_start", 32'(bus.busy[0]), 1);
    check("t1_done_start", 32'(bus.done[0]), 0);
    wait_pulse(0, 20, lat);
    check("t1_latency", 32'(lat), 6);
    check("t1_busy_at_pulse", 32'(bus.busy[0]), 0);
    check("t1_done_at_pulse", 32'(bus.done[0]), 1);
    check("t1_any_at_pulse", 32'(bus.any_pulse), 1);
    step();
    check("t1_pulse_one_cycle", 32'(bus.pulse[0]), 0);
    step(5);
    check("t1_done_sticky", 32'(bus.done[0]), 1);
    $display("seq t1 ch0 oneshot P=5 latency=%0d", lat);

    for (int v = 0; v < 6; v++) begin
      set_chan(vecs[v].ch, vecs[v].m, vecs[v].p);
      start_ch(vecs[v].ch);
      check("vec_busy_start", 32'(bus.busy[vecs[v].ch]), 1);
      wait_pulse(vecs[v].ch, 40, lat);
      check("vec_latency", 32'(lat), 32'(vecs[v].exp_lat));
      check("vec_busy_at_pulse", 32'(bus.busy[vecs[v].ch]), 32'(vecs[v].exp_busy));
      check("vec_done_at_pulse", 32'(bus.done[vecs[v].ch]), 32'(vecs[v].exp_done));
      check("vec_any_at_pulse", 32'(bus.any_pulse), 1);
      $display("vec %0d ch%0d mode=%0d P=%0d latency=%0d busy=%0d done=%0d",
               v, vecs[v].ch, vecs[v].m, vecs[v].p, lat,
               bus.busy[vecs[v].ch], bus.done[vecs[v].ch]);
      stop_ch(vecs[v].ch);
      check("vec_busy_after_stop", 32'(bus.busy[vecs[v].ch]), 0);
      step();
    end

    // Periodic P=3 on ch1, then period change mid-run
    set_chan(1, 1'b1, 3);
    start_ch(1);
    for (int k = 0; k < 10; k++) begin
      wait_pulse(1, 10, lat);
      check("t2_spacing4", 32'(lat), 4);
    end
    check("t2_busy_running", 32'(bus.busy[1]), 1);
    set_chan(1, 1'b1, 7);
    wait_pulse(1, 20, lat);
    check("t2_spacing_before_reload", 32'(lat), 4);
    wait_pulse(1, 20, lat);
    check("t2_spacing8_a", 32'(lat), 8);
    wait_pulse(1, 20, lat);
    check("t2_spacing8_b", 32'(lat), 8);
    $display("seq t2 ch1 periodic P=3->7 last spacing=%0d", lat);
    stop_ch(1);

    // Periodic P=0 on ch2, then stop
    set_chan(2, 1'b1, 0);
    start_ch(2);
    check("t3_pulse_after_start", 32'(bus.pulse[2]), 0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_pulse_every_cycle", 32'(bus.pulse[2]), 1);
      check("t3_busy", 32'(bus.busy[2]), 1);
    end
    stop_ch(2);
    check("t3_pulse_after_stop", 32'(bus.pulse[2]), 0);
    check("t3_busy_after_stop", 32'(bus.busy[2]), 0);
    check("t3_any_after_stop", 32'(bus.any_pulse), 0);
    $display("seq t3 ch2 periodic P=0 stopped busy=%0d", bus.busy[2]);

    // One-shot P=10 on ch0 retriggered when cnt=8
    set_chan(0, 1'b0, 10);
    start_ch(0);
    check("t4_done_cleared", 32'(bus.done[0]), 0);
    step(8);
    start_ch(0);
    wait_pulse(0, 30, lat);
    check("t4_retrigger_latency", 32'(lat), 11);
    check("t4_done", 32'(bus.done[0]), 1);
    $display("seq t4 ch0 retrigger latency=%0d", lat);

    // Stop at terminal count, then start+stop together, on ch3
    set_chan(3, 1'b0, 4);
    start_ch(3);
    check("t5_done_cleared", 32'(bus.done[3]), 0);
    step(4);
    stop_ch(3);
    check("t5_tc_stop_pulse", 32'(bus.pulse[3]), 0);
    check("t5_tc_stop_busy", 32'(bus.busy[3]), 0);
    check("t5_tc_stop_done", 32'(bus.done[3]), 0);
    check("t5_tc_stop_any", 32'(bus.any_pulse), 0);
    count_pulses(3, 6, npul);
    check("t5_tc_no_pulse", 32'(npul), 0);
    bus.start[3] = 1'b1;
    bus.stop[3]  = 1'b1;
    step();
    bus.start[3] = 1'b0;
    bus.stop[3]  = 1'b0;
    check("t5_both_busy", 32'(bus.busy[3]), 0);
    count_pulses(3, 8, npul);
    check("t5_both_no_pulse", 32'(npul), 0);
    check("t5_both_done", 32'(bus.done[3]), 0);
    $display("seq t5 ch3 stop priority pulses=%0d", npul);

    // All four running, reset mid-run, then long period
    set_chan(0, 1'b1, 2);
    set_chan(1, 1'b1, 3);
    set_chan(2, 1'b1, 4);
    set_chan(3, 1'b0, 1023);
    bus.start = 4'hF;
    step();
    bus.start = 4'h0;
    step(6);
    check("t6_busy_all", 32'(bus.busy), 32'hF);
    check("t6_pulse_ch0", 32'(bus.pulse), 32'h1);
    check("t6_any", 32'(bus.any_pulse), 1);
    rst_n = 1'b0;
    #2;
    check("t6_rst_pulse", 32'(bus.pulse), 0);
    check("t6_rst_busy", 32'(bus.busy), 0);
    check("t6_rst_done", 32'(bus.done), 0);
    check("t6_rst_any", 32'(bus.any_pulse), 0);
    step();
    rst_n = 1'b1;
    step(3);
    check("t6_post_rst_busy", 32'(bus.busy), 0);
    check("t6_post_rst_pulse", 32'(bus.pulse), 0);
    start_ch(3);
    wait_pulse(3, 1100, lat);
    check("t6_long_latency", 32'(lat), 1024);
    check("t6_long_done", 32'(bus.done[3]), 1);
    $display("seq t6 reset mid-run, ch3 P=1023 latency=%0d", lat);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
